// File: rtl/int_to_float_pipe.sv
// Three-stage integer to IEEE-754 converter with valid/ready flow control.
// Rounds to nearest-even and flags inexact results.
module int_to_float_pipe #(
  parameter int IN_W  = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_signed,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_data,
  output logic                     out_inexact,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int PW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int FW = 1 + EXP_W + MAN_W;
  localparam int XW = ((EXP_W > PW) ? EXP_W : PW) + 2;
  localparam int NW = IN_W + MAN_W;
  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic             vld;
    logic             sgn;
    logic             zero;
    logic [IN_W-1:0]  mag;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic             sgn;
    logic             zero;
    logic [PW-1:0]    p;
    logic [IN_W-2:0]  frac;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic             vld;
    logic             inex;
    logic [FW-1:0]    data;
    logic [TAG_W-1:0] tag;
  } s3_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  logic en;

  logic [PW-1:0]    p_c;
  logic [PW-1:0]    sh_c;
  logic [NW-1:0]    ext_c;
  logic [MAN_W-1:0] mant_c;
  logic             g_c;
  logic             st_c;
  logic             up_c;
  logic [MAN_W:0]   mant_r_c;
  logic             cy_c;
  logic [XW-1:0]    be_c;
  logic             ovf_c;

  assign en = !s3_q.vld || out_ready;

  always_comb begin
    s1_d = s1_q;
    if (en) begin
      s1_d.vld  = in_valid;
      s1_d.sgn  = in_signed & in_data[IN_W-1];
      s1_d.mag  = s1_d.sgn ? -in_data : in_data;
      s1_d.zero = (in_data == '0);
      s1_d.tag  = in_tag;
    end
  end

  // Leading one is shifted out of the top; only the fraction is kept.
  always_comb begin
    p_c = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_q.mag[i]) p_c = PW'(i);
    end
    sh_c = PW'(IN_W - 1) - p_c;
    s2_d = s2_q;
    if (en) begin
      s2_d.vld  = s1_q.vld;
      s2_d.sgn  = s1_q.sgn;
      s2_d.zero = s1_q.zero;
      s2_d.p    = p_c;
      s2_d.frac = s1_q.mag[IN_W-2:0] << sh_c;
      s2_d.tag  = s1_q.tag;
    end
  end

  always_comb begin
    ext_c    = {s2_q.frac, {(MAN_W+1){1'b0}}};
    mant_c   = ext_c[NW-1 -: MAN_W];
    g_c      = ext_c[IN_W-1];
    st_c     = |ext_c[IN_W-2:0];
    up_c     = g_c & (st_c | mant_c[0]);
    mant_r_c = {1'b0, mant_c} + (MAN_W+1)'(up_c);
    cy_c     = mant_r_c[MAN_W];
    be_c     = XW'(s2_q.p) + BIAS + XW'(cy_c);
    ovf_c    = (be_c >= EMAX);
    s3_d = s3_q;
    if (en) begin
      s3_d.vld = s2_q.vld;
      s3_d.tag = s2_q.tag;
      if (s2_q.zero) begin
        s3_d.data = '0;
        s3_d.inex = 1'b0;
      end else if (ovf_c) begin
        s3_d.data = {s2_q.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        s3_d.inex = 1'b1;
      end else begin
        s3_d.data = {s2_q.sgn, be_c[EXP_W-1:0], mant_r_c[MAN_W-1:0]};
        s3_d.inex = g_c | st_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign in_ready    = en;
  assign out_valid   = s3_q.vld;
  assign out_data    = s3_q.data;
  assign out_inexact = s3_q.inex;
  assign out_tag     = s3_q.tag;

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Bench for int_to_float_pipe: directed vectors, arithmetic reference model,
// scoreboard compare every cycle, backpressure, reset and 64-bit checks.
module tb_int_to_float_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;
  logic [3:0]  out_tag;

  logic        in_valid64;
  logic        in_ready64;
  logic [63:0] in_data64;
  logic        in_signed64;
  logic [3:0]  in_tag64;
  logic        out_valid64;
  logic [63:0] out_data64;
  logic        out_inexact64;
  logic [3:0]  out_tag64;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit bp = 0;

  typedef struct {
    logic [31:0] d;
    logic        inex;
    logic [3:0]  tag;
    int          acc;
    bit          nobp;
  } exp_t;

  exp_t sb[$];

  int_to_float_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inexact(out_inexact), .out_tag(out_tag)
  );

  int_to_float_pipe #(.IN_W(64), .EXP_W(11), .MAN_W(52), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .in_data(in_data64), .in_signed(in_signed64), .in_tag(in_tag64),
    .out_valid(out_valid64), .out_ready(1'b1),
    .out_data(out_data64), .out_inexact(out_inexact64), .out_tag(out_tag64)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference: value = m, rounded by remainder against half an ulp.
  function automatic logic [64:0] model(input logic [63:0] d, input bit sgn,
                                        input int iw, input int ew, input int mw);
    logic [64:0] v, m, q, rem, half;
    logic [63:0] bits;
    int p, sh, e;
    bit s, inex;
    v = (iw == 64) ? {1'b0, d} : {1'b0, d & ((64'd1 << iw) - 1)};
    s = sgn && v[iw-1];
    m = s ? ((65'd1 << iw) - v) : v;
    if (m == 0) return '0;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    inex = 0;
    if (p <= mw) q = m << (mw - p);
    else begin
      sh = p - mw;
      q = m >> sh;
      rem = m - (q << sh);
      half = 65'd1 << (sh - 1);
      inex = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (65'd1 << (mw + 1))) begin
        q = q >> 1;
        p++;
      end
    end
    e = p + (1 << (ew - 1)) - 1;
    if (e >= (1 << ew) - 1) begin
      bits = (64'(s) << (ew + mw)) | (64'((1 << ew) - 1) << mw);
      inex = 1;
    end else begin
      bits = (64'(s) << (ew + mw)) | (64'(e) << mw) | (q[63:0] - (64'd1 << mw));
    end
    return {inex, bits};
  endfunction

  task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    bit stall;
    logic [36:0] held;
    logic [64:0] r;
    exp_t e;
    stall = 0;
    held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        stall = 0;
      end else begin
        chk("in_ready", 65'(in_ready), 65'(!out_valid || out_ready));
        if (stall) begin
          chk("stall_valid", 65'(out_valid), 65'd1);
          chk("stall_hold", 65'({out_inexact, out_tag, out_data}), 65'(held));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out got=%h exp=none", out_data);
          end else begin
            e = sb.pop_front();
            chk("out_data", 65'(out_data), 65'(e.d));
            chk("out_inexact", 65'(out_inexact), 65'(e.inex));
            chk("out_tag", 65'(out_tag), 65'(e.tag));
            if (e.nobp) chk("latency", 65'(cyc - e.acc), 65'd3);
          end
        end
        stall = out_valid && !out_ready;
        held = {out_inexact, out_tag, out_data};
        if (in_valid && in_ready) begin
          r = model({32'd0, in_data}, in_signed, 32, 8, 23);
          sb.push_back('{d: r[31:0], inex: r[64], tag: in_tag, acc: cyc, nobp: !bp});
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit sgn, input logic [3:0] tag);
    int n;
    in_valid = 1;
    in_data = d;
    in_signed = sgn;
    in_tag = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=stalled exp=accept");
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic vec(input logic [31:0] d, input bit sgn, input logic [31:0] xd,
                     input bit xi, input logic [3:0] tag);
    logic [64:0] r;
    r = model({32'd0, d}, sgn, 32, 8, 23);
    chk("pin_data", 65'(r[31:0]), 65'(xd));
    chk("pin_inex", 65'(r[64]), 65'(xi));
    send(d, sgn, tag);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 65'(sb.size()), 65'd0);
  endtask

  task automatic v64(input logic [63:0] d, input bit sgn, input logic [63:0] xd, input bit xi);
    logic [64:0] r;
    r = model(d, sgn, 64, 11, 52);
    chk("pin64_data", 65'(r[63:0]), 65'(xd));
    chk("pin64_inex", 65'(r[64]), 65'(xi));
    in_valid64 = 1;
    in_data64 = d;
    in_signed64 = sgn;
    in_tag64 = 4'hA;
    chk("in_ready64", 65'(in_ready64), 65'd1);
    @(posedge clk);
    #1;
    in_valid64 = 0;
    @(posedge clk);
    #1;
    chk("out_valid64_early", 65'(out_valid64), 65'd0);
    @(posedge clk);
    #1;
    chk("out_valid64", 65'(out_valid64), 65'd1);
    chk("out_data64", 65'(out_data64), 65'(xd));
    chk("out_inexact64", 65'(out_inexact64), 65'(xi));
    chk("out_tag64", 65'(out_tag64), 65'hA);
  endtask

  logic [31:0] bpv [10] = '{32'd7, 32'hFFFFFFF9, 32'h00FFFFFF, 32'h01000001,
                            32'h7FFFFFFF, 32'h80000001, 32'd12345678,
                            32'hDEADBEEF, 32'd100, 32'h12345679};

  initial begin
    rst_n = 0;
    in_valid = 0; in_data = '0; in_signed = 0; in_tag = '0;
    in_valid64 = 0; in_data64 = '0; in_signed64 = 0; in_tag64 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 65'(out_valid), 65'd0);
    chk("rst_out_data", 65'(out_data), 65'd0);
    chk("rst_out_inexact", 65'(out_inexact), 65'd0);
    chk("rst_out_tag", 65'(out_tag), 65'd0);
    chk("rst_in_ready", 65'(in_ready), 65'd1);
    chk("rst_out_valid64", 65'(out_valid64), 65'd0);
    rst_n = 1;
    @(posedge clk);
    #1;

    vec(32'd1,        0, 32'h3F800000, 0, 4'd1);
    vec(32'd1,        1, 32'h3F800000, 0, 4'd2);
    vec(32'hFFFFFFFF, 1, 32'hBF800000, 0, 4'd3);
    vec(32'd0,        0, 32'h00000000, 0, 4'd4);
    vec(32'h80000000, 1, 32'hCF000000, 0, 4'd5);
    vec(32'h80000000, 0, 32'h4F000000, 0, 4'd6);
    vec(32'd16777217, 0, 32'h4B800000, 1, 4'd7);
    vec(32'd16777219, 0, 32'h4B800002, 1, 4'd8);
    vec(32'hFFFFFFFF, 0, 32'h4F800000, 1, 4'd9);
    vec(32'd0,        1, 32'h00000000, 0, 4'd10);
    vec(32'd3,        0, 32'h40400000, 0, 4'd11);
    vec(32'hFFFFFFFB, 1, 32'hC0A00000, 0, 4'd12);
    vec(32'h7FFFFFFF, 1, 32'h4F000000, 1, 4'd13);
    drain();

    bp = 1;
    for (int i = 0; i < 10; i++) send(bpv[i], bit'(i % 2), 4'(i));
    drain();
    bp = 0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) send(32'd100 + 32'(i), 0, 4'(i));
    rst_n = 0;
    #1;
    chk("async_rst_valid", 65'(out_valid), 65'd0);
    chk("async_rst_ready", 65'(in_ready), 65'd1);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", 65'(out_valid), 65'd0);
    vec(32'd5, 0, 32'h40A00000, 0, 4'd15);
    drain();

    v64(64'h0020000000000001, 0, 64'h4340000000000000, 1);
    v64(64'hFFFFFFFFFFFFFFFF, 1, 64'hBFF0000000000000, 0);
    v64(64'h8000000000000000, 1, 64'hC3E0000000000000, 0);
    v64(64'hFFFFFFFFFFFFFFFF, 0, 64'h43F0000000000000, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
